// File: rtl/spi_param_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        TRAIL,
        NEXT,
        GAP
    } state_t;

    // SPI mode numbering as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int cs_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: counts 0..i_div while i_run is high and strobes o_tick
// on the final count, restarting from zero on the following cycle.
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = i_run && (r_cnt == i_div);
    assign o_tick = w_tick;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_run || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, chip selects, CPOL/CPHA,
// bit order and SCK divider, with CS held across multi-word bursts.
module spi_master_param
    import spi_param_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CS_N     = 4,
    parameter int DIV_W    = 8,
    parameter int CS_SEL_W = cs_sel_w(CS_N)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [DIV_W-1:0]    div,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                msb_first,
    input  logic [CS_SEL_W-1:0] cs_sel,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_last,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                sck,
    output logic [CS_N-1:0]     cs_n,
    output logic                sdo,
    input  logic                sdi
);

    localparam int                EDGE_W    = $clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

    state_t              r_state;
    state_t              w_next_state;

    logic [DIV_W-1:0]    r_div;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_msb_first;
    logic                r_last;
    logic [DATA_W-1:0]   r_shift;
    logic [EDGE_W-1:0]   r_edge;
    logic                r_sck_int;
    logic                r_sdo;
    logic [CS_N-1:0]     r_cs_n;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;

    logic                w_run;
    logic                w_tick;
    logic                w_hs;
    logic                w_trail_sample;
    logic [EDGE_W-1:0]   w_k;
    logic                w_sample;
    logic                w_drive;
    logic [DATA_W-1:0]   w_shifted;

    function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic msb);
        return msb ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                   input logic msb, input logic b);
        return msb ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
    endfunction

    // An out-of-range index decodes to no asserted select.
    function automatic logic [CS_N-1:0] cs_decode(input logic [CS_SEL_W-1:0] sel);
        logic [CS_N-1:0] v;
        v = '1;
        for (int i = 0; i < CS_N; i++) begin
            if (32'(sel) == 32'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk    (clk),
        .reset  (reset),
        .i_run  (w_run),
        .i_div  (r_div),
        .o_tick (w_tick)
    );

    assign w_hs      = tx_valid && tx_ready;
    assign w_k       = r_edge + EDGE_W'(1);
    assign w_shifted = shift_in(r_shift, r_msb_first, sdi);

    always_comb begin
        w_trail_sample = 1'b0;
        case ({r_cpol, r_cpha})
            SPI_MODE0, SPI_MODE2: w_trail_sample = 1'b0;
            SPI_MODE1, SPI_MODE3: w_trail_sample = 1'b1;
            default:              w_trail_sample = 1'b0;
        endcase
    end

    // Leading-edge sampling uses odd edges; trailing-edge sampling uses even edges.
    assign w_sample = w_trail_sample ? ~w_k[0] : w_k[0];
    assign w_drive  = w_trail_sample ? w_k[0] : (~w_k[0] && (w_k != LAST_EDGE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next_state = SHIFT;
            SHIFT:   if (w_tick && (w_k == LAST_EDGE)) w_next_state = TRAIL;
            TRAIL:   if (w_tick) w_next_state = r_last ? GAP : NEXT;
            NEXT:    if (w_hs) w_next_state = SHIFT;
            GAP:     if (w_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (!en) w_next_state = IDLE;
    end

    always_comb begin
        tx_ready = 1'b0;
        w_run    = 1'b0;
        busy     = (r_state != IDLE);
        case (r_state)
            IDLE, NEXT:       tx_ready = en && !reset;
            SHIFT, TRAIL, GAP: w_run   = en;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_msb_first <= 1'b0;
            r_last      <= 1'b0;
            r_shift     <= '0;
            r_edge      <= '0;
            r_sck_int   <= 1'b0;
            r_sdo       <= 1'b1;
            r_cs_n      <= '1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else if (!en) begin
            r_div       <= '0;
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_msb_first <= 1'b0;
            r_last      <= 1'b0;
            r_shift     <= '0;
            r_edge      <= '0;
            r_sck_int   <= 1'b0;
            r_sdo       <= 1'b1;
            r_cs_n      <= '1;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_div       <= div;
                        r_cpol      <= cpol;
                        r_cpha      <= cpha;
                        r_msb_first <= msb_first;
                        r_last      <= tx_last;
                        r_shift     <= tx_data;
                        r_edge      <= '0;
                        r_sck_int   <= 1'b0;
                        r_cs_n      <= cs_decode(cs_sel);
                        r_sdo       <= cpha ? 1'b1 : out_bit(tx_data, msb_first);
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sck_int <= ~r_sck_int;
                        r_edge    <= w_k;
                        if (w_sample) r_shift <= w_shifted;
                        if (w_drive)  r_sdo   <= out_bit(r_shift, r_msb_first);
                        // The trailing-edge mode takes its last sample on this same edge.
                        if (w_k == LAST_EDGE) begin
                            r_edge     <= '0;
                            r_rx_data  <= w_sample ? w_shifted : r_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                TRAIL: begin
                    if (w_tick && r_last) begin
                        r_cs_n <= '1;
                        r_sdo  <= 1'b1;
                    end
                end
                NEXT: begin
                    if (w_hs) begin
                        r_shift <= tx_data;
                        r_last  <= tx_last;
                        r_edge  <= '0;
                        if (!r_cpha) r_sdo <= out_bit(tx_data, r_msb_first);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sck      = r_sck_int ^ r_cpol;
    assign cs_n     = r_cs_n;
    assign sdo      = r_sdo;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: modes, bursts, abort, reset and an
// out-of-range chip select on a second instance with CS_N=5.
module tb_spi_master_param;
    import spi_param_pkg::*;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             cpol;
    logic             cpha;
    logic             msb_first;
    logic [1:0]       cs_sel;
    logic [2:0]       cs_sel5;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_valid;
    logic             loop_en;
    logic             sdi_val;

    logic             tx_ready, rx_valid, busy, sck, sdo, sdi;
    logic [7:0]       rx_data;
    logic [3:0]       cs_n;
    logic             tx_ready5, rx_valid5, busy5, sck5, sdo5;
    logic [7:0]       rx_data5;
    logic [4:0]       cs_n5;

    assign sdi = loop_en ? sdo : sdi_val;

    always #5 clk = ~clk;

    spi_master_param #(.DATA_W(DATA_W), .CS_N(4), .DIV_W(DIV_W)) u_dut (
        .clk(clk), .reset(reset), .en(en), .div(div), .cpol(cpol), .cpha(cpha),
        .msb_first(msb_first), .cs_sel(cs_sel), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .sck(sck), .cs_n(cs_n), .sdo(sdo), .sdi(sdi)
    );

    spi_master_param #(.DATA_W(DATA_W), .CS_N(5), .DIV_W(DIV_W)) u_dut5 (
        .clk(clk), .reset(reset), .en(en), .div(div), .cpol(cpol), .cpha(cpha),
        .msb_first(msb_first), .cs_sel(cs_sel5), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready5), .rx_data(rx_data5), .rx_valid(rx_valid5),
        .busy(busy5), .sck(sck5), .cs_n(cs_n5), .sdo(sdo5), .sdi(sdo5)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Free-running observers; tests take snapshots and compare deltas.
    int         cyc = 0;
    int         n_edges = 0, n_rises = 0, n_rx = 0, n_cs_match = 0, n_cs_bad = 0, n_gap = 0;
    int         last_edge_cyc = 0, last_hp = 0;
    int         n5_cs_low = 0, n5_rx = 0, n5_edges = 0;
    logic       prev_sck = 1'b0, prev_sck5 = 1'b0;
    logic [7:0] sdo_hist = '0, rx_h0 = '0, rx_h1 = '0, rx_h2 = '0;
    logic [3:0] exp_cs = 4'hF;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sck !== prev_sck) begin
            n_edges++;
            last_hp       = cyc - last_edge_cyc;
            last_edge_cyc = cyc;
        end
        if (sck && !prev_sck) begin
            n_rises++;
            sdo_hist = {sdo_hist[6:0], sdo};
        end
        prev_sck = sck;
        if (rx_valid) begin
            n_rx++;
            rx_h2 = rx_h1;
            rx_h1 = rx_h0;
            rx_h0 = rx_data;
        end
        if (cs_n == exp_cs) n_cs_match++;
        if (cs_n != 4'hF && cs_n != exp_cs) n_cs_bad++;
        if (busy && cs_n == 4'hF) n_gap++;
        if (cs_n5 != 5'h1F) n5_cs_low++;
        if (rx_valid5) n5_rx++;
        if (sck5 !== prev_sck5) n5_edges++;
        prev_sck5 = sck5;
    end

    task automatic cfg(input logic [7:0] d, input logic pol, input logic pha,
                       input logic msb, input logic [1:0] sel, input logic [2:0] sel5);
        div = d; cpol = pol; cpha = pha; msb_first = msb; cs_sel = sel; cs_sel5 = sel5;
    endtask

    task automatic offer(input logic [7:0] d, input logic last, output int hs_cyc);
        bit got;
        got = 1'b0;
        tx_data = d; tx_last = last; tx_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("handshake_timeout", 32'(got), 1);
        @(posedge clk);
        #1 hs_cyc = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output int rdy_cyc);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tx_ready && !busy) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("idle_timeout", 32'(got), 1);
        rdy_cyc = cyc;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},     32'(busy),     0);
        check({tag, "_cs_n"},     32'(cs_n),     32'hF);
        check({tag, "_sck"},      32'(sck),      0);
        check({tag, "_sdo"},      32'(sdo),      1);
        check({tag, "_rx_valid"}, 32'(rx_valid), 0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 0);
        check({tag, "_rx_data"},  32'(rx_data),  0);
    endtask

    int h, r, s_a, s_b, s_c, s_d;

    initial begin
        reset = 1'b1; en = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        loop_en = 1'b1; sdi_val = 1'b0;
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0);
        repeat (2) @(negedge clk);
        #1 check_quiet("rst");
        reset = 1'b0;
        @(negedge clk);

        // Mode 0, MSB first, div=0, cs_sel=2, loopback 0xA5
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0);
        exp_cs = 4'b1011;
        #1 begin s_a = n_cs_match; s_b = n_cs_bad; s_c = n_rx; s_d = n_rises; end
        offer(8'hA5, 1'b1, h);
        wait_idle(r);
        check("t1_ready_lat", 32'(r - h + 1), 19);
        #1;
        check("t1_cs_cycles", 32'(n_cs_match - s_a), 17);
        check("t1_cs_bad",    32'(n_cs_bad - s_b),   0);
        check("t1_rises",     32'(n_rises - s_d),    8);
        check("t1_sdo_bits",  32'(sdo_hist),         32'hA5);
        check("t1_rx_pulses", 32'(n_rx - s_c),       1);
        check("t1_rx_data",   32'(rx_data),          32'hA5);

        // Mode 3, LSB first, div=3, 0x3C with sdi held low
        cfg(8'd3, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0);
        exp_cs = 4'b1110; loop_en = 1'b0; sdi_val = 1'b0;
        #1 s_d = n_rises;
        offer(8'h3C, 1'b1, h);
        check("t2_sck_start", 32'(sck), 1);
        wait_idle(r);
        check("t2_ready_lat", 32'(r - h + 1), 73);
        #1;
        check("t2_half_period", 32'(last_hp),          4);
        check("t2_rises",       32'(n_rises - s_d),    9);
        check("t2_sdo_bits",    32'(sdo_hist),         32'h3C);
        check("t2_rx_data",     32'(rx_data),          32'h00);
        check("t2_sck_idle",    32'(sck),              1);

        // Three-word burst; the second word's cs_sel must be ignored
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0);
        exp_cs = 4'b1101; loop_en = 1'b1;
        #1 begin s_a = n_rx; s_b = n_cs_bad; s_c = n_gap; end
        offer(8'h11, 1'b0, h);
        cs_sel = 2'd3;
        offer(8'h22, 1'b0, h);
        offer(8'h33, 1'b1, h);
        wait_idle(r);
        #1;
        check("t3_rx_pulses", 32'(n_rx - s_a),     3);
        check("t3_rx_word0",  32'(rx_h2),          32'h11);
        check("t3_rx_word1",  32'(rx_h1),          32'h22);
        check("t3_rx_word2",  32'(rx_h0),          32'h33);
        check("t3_cs_bad",    32'(n_cs_bad - s_b), 0);
        check("t3_gap_cycles", 32'(n_gap - s_c),   1);

        // Abort with en low after the fifth SCK edge, then a clean frame
        cfg(8'd1, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0);
        exp_cs = 4'b1110;
        #1 s_a = n_edges;
        offer(8'h96, 1'b1, h);
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                #1;
                if (n_edges - s_a >= 5) begin
                    got = 1'b1;
                    break;
                end
            end
            check("t4_edge5_seen", 32'(got), 1);
        end
        en = 1'b0;
        s_b = n_rx;
        @(negedge clk);
        #1 check_quiet("t4_abort");
        repeat (20) @(negedge clk);
        #1 check("t4_no_rx", 32'(n_rx - s_b), 0);
        en = 1'b1;
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0);
        offer(8'h5A, 1'b1, h);
        wait_idle(r);
        check("t4_rx_after", 32'(rx_data), 32'h5A);

        // Out-of-range select on the CS_N=5 instance
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd5);
        #1 begin s_a = n5_cs_low; s_b = n5_rx; s_c = n5_edges; end
        offer(8'h69, 1'b1, h);
        wait_idle(r);
        #1;
        check("t5_cs_low",    32'(n5_cs_low - s_a), 0);
        check("t5_rx_pulses", 32'(n5_rx - s_b),     1);
        check("t5_sck_edges", 32'(n5_edges - s_c),  16);
        check("t5_rx_data",   32'(rx_data5),        32'h69);

        // Reset in the middle of SHIFT, then a clean frame
        cfg(8'd0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0);
        exp_cs = 4'b1011;
        offer(8'hE7, 1'b1, h);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1 check_quiet("t6_reset");
        @(negedge clk);
        reset = 1'b0;
        #1 s_a = n_rx;
        offer(8'h81, 1'b1, h);
        wait_idle(r);
        #1;
        check("t6_rx_data",   32'(rx_data),     32'h81);
        check("t6_rx_pulses", 32'(n_rx - s_a),  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised successor to the single-byte SPI master: configurable word width, N chip selects, all four CPOL/CPHA modes, MSB/LSB first, and a programmable SCK divider.
- Takes words over a valid/ready stream and returns received words as a one-cycle pulse.
- Supports multi-word bursts with CS held low between words, plus an enforced CS-high gap between frames.
- Sits between a register/CPU front end and the SPI pins.

Parameters:
DATA_W, 8, bits per SPI word (>=2)
CS_N, 4, number of chip-select outputs (>=1)
DIV_W, 8, width of divider field
CS_SEL_W, (CS_N>1 ? $clog2(CS_N) : 1), derived, width of cs_sel

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  block enable; low = synchronous abort/clear
div  in  DIV_W  SCK half-period = div+1 clk cycles
cpol  in  1  SCK idle level
cpha  in  1  0: sample leading edge; 1: sample trailing edge
msb_first  in  1  1: MSB shifted first
cs_sel  in  CS_SEL_W  slave index for the frame
tx_data  in  DATA_W  word to send
tx_last  in  1  word ends the frame
tx_valid  in  1  word offered
tx_ready  out  1  word accepted when tx_valid&tx_ready
rx_data  out  DATA_W  last received word
rx_valid  out  1  one-cycle pulse, rx_data valid
busy  out  1  state != IDLE
sck  out  1  SPI clock
cs_n  out  CS_N  active-low selects
sdo  out  1  serial out
sdi  in  1  serial in

Behaviour:
- Reset (async, high): state=IDLE; all latched config=0; cs_n=all 1; sck=0; sdo=1; rx_data=0; rx_valid=0; tx_ready=0; busy=0.
- en=0: next clk forces the same values as reset, aborts any frame, no rx_valid.
- sck = sck_int ^ cpol_q.
- States: IDLE, SHIFT, TRAIL, NEXT, GAP.
- Half-period counter div_c: runs 0..div_q in SHIFT/TRAIL/GAP; a half-period ends when div_c==div_q, and div_c then clears.
- IDLE: tx_ready=en.
  - On handshake: latch div, cpol, cpha, msb_first, cs_sel, tx_data, tx_last; div_c=0; go SHIFT.
  - If cpha=0, sdo = first bit, driven on the same edge.
  - cs_n[cs_sel_q] goes low on entry to SHIFT. If cs_sel>=CS_N, no line asserts; the transfer still runs.
- SHIFT: 2*DATA_W half-periods. Each half-period end is edge k=1..2*DATA_W: sck_int toggles on that clk edge.
  - cpha=0: sample sdi on odd k. Drive the next bit on even k<2*DATA_W.
  - cpha=1: drive a bit on odd k. Sample sdi on even k.
  - Sampling shifts into the data register; the direction follows msb_first_q.
  - After k=2*DATA_W: rx_data<=register, rx_valid=1 for the first TRAIL cycle; go TRAIL.
- TRAIL: one half-period, sck idle, CS held.
  - If last_q=1: go GAP.
  - Else: go NEXT.
- NEXT: CS held, tx_ready=1.
  - On handshake: latch tx_data and tx_last only; cs_sel/mode/div fields are ignored; go SHIFT.
  - For cpha=0, the first bit is driven at the handshake.
- GAP: cs_n all 1, sdo=1, one half-period; then IDLE.
- Timing (div=d, handshake cycle T): cs_n low T+1..T+(2*DATA_W+1)(d+1); tx_ready back at T+1+(2*DATA_W+2)(d+1).
- sdo before the first drive in cpha=1 = 1.
- rx_valid has no backpressure. rx_data holds until the next word completes.
- Simultaneous en=0 and handshake: en wins, nothing latched.

Decomposition:
- Package spi_param_pkg: state enum (IDLE, SHIFT, TRAIL, NEXT, GAP), mode encoding constants, CS_SEL_W function.
- Sub-module spi_clk_div: half-period counter, takes div_q and run, emits edge strobe.

Test Plan:
- DATA_W=8, CS_N=4, sdi looped to sdo, mode 0, msb_first, div=0, cs_sel=2, 0xA5, last -> cs_n=1011 for 17 cycles; sdo 1,0,1,0,0,1,0,1 at sck rises; rx_data=0xA5, one rx_valid; tx_ready high at T+19.
- Mode 3, LSB first, div=3, 0x3C, sdi=0 -> sck idles 1, 4-cycle half-period; sdo 0,0,1,1,1,1,0,0; rx_data=0x00.
- Burst of 0x11 (cs_sel=1), 0x22 (cs_sel=3 ignored), 0x33 last -> cs_n[1] low throughout; 3 rx_valid pulses of 0x11/0x22/0x33; one GAP at end.
- en dropped after edge 5 -> next cycle IDLE; cs_n=1111, sck=0, sdo=1, no rx_valid; next frame 0x5A returns 0x5A.
- reset raised mid-SHIFT -> same cycle all outputs at reset values, busy=0; clean frame after release.
- cs_sel=5 (>=CS_N) -> cs_n stays 1111; 16 sck edges still generated; rx_valid pulses once.
